// File: rtl/prga_if.sv
// Handshake and memory-port bundle between the ARC4 controller/memories
// and the pseudo-random generation stage.
interface prga_if;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;

  // Controller / memory side: issues start, returns read data.
  modport master (
    output en, s_rddata, ct_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

  // PRGA side: accepts start, drives addresses and writes.
  modport slave (
    input  en, s_rddata, ct_rddata,
    output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );
endinterface

// File: rtl/prga.sv
// ARC4 pseudo-random generation stage: walks the length-prefixed ciphertext,
// permutes S in place and writes the length-prefixed plaintext.
// Every memory output is decoded from the current state, so a reset drops
// all write enables in the same instant.
module prga (
  input  logic     clk,
  input  logic     rst,
  prga_if.slave    bus
);

  typedef enum logic [3:0] {
    IDLE, LEN_RD, LEN_WR, SI_RD, SJ_RD, SWAP_I, SWAP_J, PAD_RD, PT_WR
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] k_q, k_d;
  logic [7:0] len_q, len_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [7:0] ctb_q, ctb_d;

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= 8'd0;
      len_q   <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      ctb_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      ctb_q   <= ctb_d;
    end
  end

  // Next-state, register updates and memory-port decode per state.
  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    len_d         = len_q;
    si_d          = si_q;
    sj_d          = sj_q;
    ctb_d         = ctb_q;
    bus.rdy       = 1'b0;
    bus.s_addr    = 8'd0;
    bus.s_wrdata  = 8'd0;
    bus.s_wren    = 1'b0;
    bus.ct_addr   = 8'd0;
    bus.pt_addr   = 8'd0;
    bus.pt_wrdata = 8'd0;
    bus.pt_wren   = 1'b0;

    case (state_q)
      IDLE: begin
        bus.rdy = 1'b1;
        if (bus.en) begin
          i_d     = 8'd1;
          j_d     = 8'd0;
          k_d     = 8'd1;
          state_d = LEN_RD;
        end
      end
      LEN_RD: begin
        bus.ct_addr = 8'd0;
        state_d     = LEN_WR;
      end
      LEN_WR: begin
        len_d         = bus.ct_rddata;
        bus.pt_addr   = 8'd0;
        bus.pt_wrdata = bus.ct_rddata;
        bus.pt_wren   = 1'b1;
        state_d       = (bus.ct_rddata == 8'd0) ? IDLE : SI_RD;
      end
      SI_RD: begin
        bus.s_addr = i_q;
        state_d    = SJ_RD;
      end
      SJ_RD: begin
        // j advances by S[i]; S[j] is fetched with the new j directly.
        si_d       = bus.s_rddata;
        j_d        = j_q + bus.s_rddata;
        bus.s_addr = j_q + bus.s_rddata;
        state_d    = SWAP_I;
      end
      SWAP_I: begin
        sj_d         = bus.s_rddata;
        bus.s_addr   = i_q;
        bus.s_wrdata = bus.s_rddata;
        bus.s_wren   = 1'b1;
        state_d      = SWAP_J;
      end
      SWAP_J: begin
        // When i==j this second write restores the original value.
        bus.s_addr   = j_q;
        bus.s_wrdata = si_q;
        bus.s_wren   = 1'b1;
        bus.ct_addr  = k_q;
        state_d      = PAD_RD;
      end
      PAD_RD: begin
        // Pre-swap si+sj equals post-swap S[i]+S[j].
        ctb_d      = bus.ct_rddata;
        bus.s_addr = si_q + sj_q;
        state_d    = PT_WR;
      end
      PT_WR: begin
        bus.pt_addr   = k_q;
        bus.pt_wrdata = bus.s_rddata ^ ctb_q;
        bus.pt_wren   = 1'b1;
        if (k_q == len_q) begin
          state_d = IDLE;
        end else begin
          k_d     = k_q + 8'd1;
          i_d     = i_q + 8'd1;
          state_d = SI_RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
